// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - handshaked ALU: single-cycle logic/arith ops, N-cycle shift-add MUL and restoring DIV, registered NZCV
module alu_multicycle #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] result,
  output logic [3:0]     flags,
  output logic           div_by_zero
);

  localparam int CW = $clog2(N);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;
  localparam logic [2:0] OP_DIV = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [2:0]      op_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    hi_q;
  logic [N-1:0]    lo_q;
  logic [N:0]      rem_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            iter_op;

  logic [N:0]      sum;
  logic [N:0]      dif;
  logic [N-1:0]    alu_res;
  logic            alu_c;
  logic            alu_v;

  logic [N:0]      mul_add;
  logic [N-1:0]    mul_hi_n;
  logic [N-1:0]    mul_lo_n;

  logic [N:0]      trial;
  logic [N+1:0]    div_dif;
  logic            div_ge;
  logic [N:0]      rem_n;
  logic [N-1:0]    quo_n;
  logic            div_zero;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign iter_op   = (op == OP_MUL) || (op == OP_DIV);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = iter_op ? RUN : DONE;
      RUN:     if (cnt_q == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ops are evaluated straight from the inputs at the accept edge.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    dif     = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[N-1:0];
        alu_c   = sum[N];
        alu_v   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = dif[N-1:0];
        alu_c   = ~dif[N];
        alu_v   = (a[N-1] != b[N-1]) && (dif[N-1] != a[N-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_ORR:  alu_res = a | b;
      OP_MOV:  alu_res = b;
      default: alu_res = '0;
    endcase
  end

  // MUL step: {hi_q, lo_q} is the accumulator, multiplier bits consumed from lo_q[0].
  always_comb begin
    mul_add  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, a_q}) : {1'b0, hi_q};
    mul_hi_n = mul_add[N:1];
    mul_lo_n = {mul_add[0], lo_q[N-1:1]};
  end

  // DIV step: dividend bits shift out of lo_q MSB-first while quotient bits shift in.
  always_comb begin
    trial    = {rem_q[N-1:0], lo_q[N-1]};
    div_dif  = {1'b0, trial} - {2'b00, b_q};
    div_ge   = ~div_dif[N+1];
    rem_n    = div_ge ? div_dif[N:0] : trial;
    quo_n    = {lo_q[N-2:0], div_ge};
    div_zero = (b_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      result      <= '0;
      flags       <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            hi_q  <= '0;
            rem_q <= '0;
            lo_q  <= (op == OP_MUL) ? b : a;
            cnt_q <= CW'(N - 1);
            if (!iter_op) begin
              result      <= {{N{1'b0}}, alu_res};
              flags       <= {alu_res[N-1], alu_res == '0, alu_c, alu_v};
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          if (op_q == OP_MUL) begin
            hi_q <= mul_hi_n;
            lo_q <= mul_lo_n;
          end else begin
            rem_q <= rem_n;
            lo_q  <= quo_n;
          end
          if (cnt_q == '0) begin
            if (op_q == OP_MUL) begin
              result      <= {mul_hi_n, mul_lo_n};
              flags       <= {mul_hi_n[N-1], {mul_hi_n, mul_lo_n} == '0, 1'b0, 1'b0};
              div_by_zero <= 1'b0;
            end else begin
              result      <= {rem_n[N-1:0], quo_n};
              flags       <= {quo_n[N-1], quo_n == '0, 1'b0, div_zero};
              div_by_zero <= div_zero;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle (N=16)
module tb_alu_multicycle;

  localparam int N = 16;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] ORR = 3'b011;
  localparam logic [2:0] MUL = 3'b100;
  localparam logic [2:0] MOV = 3'b101;
  localparam logic [2:0] CMP = 3'b110;
  localparam logic [2:0] DIV = 3'b111;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] result;
  logic [3:0]     flags;
  logic           div_by_zero;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int acc_cyc     = 0;

  typedef struct {
    logic [36:0] exp;
    int          lat;
    logic [3:0]  fmask;
  } sb_t;

  sb_t sb[$];

  alu_multicycle #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .flags       (flags),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected {div_by_zero, N, Z, C, V, result[31:0]}
  function automatic logic [36:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] r;
    logic [16:0] t;
    logic        n, z, c, v, dz;
    r = '0; c = 1'b0; v = 1'b0; dz = 1'b0;
    case (o)
      ADD: begin
        t = {1'b0, x} + {1'b0, y};
        r = {16'h0, t[15:0]};
        c = t[16];
        v = (x[15] == y[15]) && (r[15] != x[15]);
      end
      SUB, CMP: begin
        r = {16'h0, x - y};
        c = (x >= y);
        v = (x[15] != y[15]) && (r[15] != x[15]);
      end
      AND: r = {16'h0, x & y};
      ORR: r = {16'h0, x | y};
      MOV: r = {16'h0, y};
      MUL: r = {16'h0, x} * {16'h0, y};
      default: begin
        if (y == 16'h0) begin
          r  = {x, 16'hFFFF};
          dz = 1'b1;
          v  = 1'b1;
        end else begin
          r = {x % y, x / y};
        end
      end
    endcase
    n = (o == MUL) ? r[31] : r[15];
    z = (o == MUL) ? (r == 32'h0) : (r[15:0] == 16'h0);
    return {dz, n, z, c, v, r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                      input bit track, input logic [3:0] fm);
    int  n;
    sb_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
    op = 3'($urandom);
    a  = 16'($urandom);
    b  = 16'($urandom);
    if (track) begin
      e.exp   = model(o, x, y);
      e.lat   = (o == MUL || o == DIV) ? 17 : 1;
      e.fmask = fm;
      sb.push_back(e);
    end
  endtask

  task automatic receive(input int hold);
    int  n;
    int  lat;
    sb_t e;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = cyc - acc_cyc + 1;
    chk("out_valid", out_valid, 1);
    chk("scoreboard_nonempty", sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("result", result, e.exp[31:0]);
    chk("flags", flags & e.fmask, e.exp[35:32] & e.fmask);
    chk("div_by_zero", div_by_zero, e.exp[36]);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op = 3'($urandom);
      a  = 16'($urandom);
      b  = 16'($urandom);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, e.exp[31:0]);
      chk("bp_flags", flags & e.fmask, e.exp[35:32] & e.fmask);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_cleared", out_valid, 0);
    chk("in_ready_after_handshake", in_ready, 1);
    chk("result_held", result, e.exp[31:0]);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [15:0] rx, ry;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_result", result, 0);
    chk("post_rst_flags", flags, 0);
    chk("post_rst_dbz", div_by_zero, 0);

    send(ADD, 16'h7FFF, 16'h0001, 1, 4'hF); receive(0);
    send(SUB, 16'h0005, 16'h0005, 1, 4'hF); receive(0);
    send(CMP, 16'h0003, 16'h0005, 1, 4'hF); receive(0);
    send(ADD, 16'h8000, 16'h8000, 1, 4'hF); receive(0);
    send(SUB, 16'h8000, 16'h0001, 1, 4'hF); receive(0);
    send(AND, 16'hF0F0, 16'h3C3C, 1, 4'hF); receive(0);
    send(ORR, 16'h0F00, 16'h8001, 1, 4'hF); receive(0);
    send(MOV, 16'h1234, 16'h0000, 1, 4'hF); receive(0);
    send(MUL, 16'h1234, 16'h0010, 1, 4'hF); receive(0);
    send(MUL, 16'hFFFF, 16'hFFFF, 1, 4'hF); receive(0);
    send(MUL, 16'h0000, 16'hABCD, 1, 4'hF); receive(0);
    send(DIV, 16'd100, 16'd7, 1, 4'hF);     receive(0);
    send(DIV, 16'h0055, 16'h0000, 1, 4'h7); receive(0);
    send(DIV, 16'hFFFF, 16'h0001, 1, 4'hF); receive(0);
    send(ADD, 16'h1234, 16'h4321, 1, 4'hF); receive(3);

    send(MUL, 16'h1234, 16'h5678, 0, 4'hF);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrun_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun_out_valid", out_valid, 0);
    chk("midrun_flags", flags, 0);
    chk("midrun_result", result, 0);
    chk("midrun_in_ready", in_ready, 1);
    send(ADD, 16'h0002, 16'h0003, 1, 4'hF); receive(0);

    for (int i = 0; i < 12; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (ro == DIV && ry == 16'h0) ry = 16'h1;
      send(ro, rx, ry, 1, 4'hF);
      receive(i % 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
